// File: rtl/mux_scan_serializer_if.sv
// Parallel-in / serial-out handshake bundle for mux_scan_serializer.
// slave is the serializer side, master is the producer/consumer side.
interface mux_scan_serializer_if #(
    parameter int SEL_W = 4
);
    localparam int N = 2 ** SEL_W;

    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     in;
    logic [SEL_W-1:0] sel;
    logic             out;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;
    logic             busy;

    modport slave (
        input  in_valid, in, out_ready,
        output in_ready, sel, out, out_valid, out_last, busy
    );

    modport master (
        output in_valid, in, out_ready,
        input  in_ready, sel, out, out_valid, out_last, busy
    );
endinterface

// File: rtl/mux_scan_serializer.sv
// Captures a parallel word and walks sel across all N positions, one bit per transfer.
// Optional MSB-first order: define MUX_SCAN_MSB_FIRST_EN.
module mux_scan_serializer #(
    parameter int SEL_W  = 4,
    parameter int SETTLE = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mux_scan_serializer_if.slave bus
);
    localparam int N = 2 ** SEL_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_PRESENT
    } state_t;

`ifdef MUX_SCAN_MSB_FIRST_EN
    localparam logic [SEL_W-1:0] SEL_FIRST = '1;
    localparam logic [SEL_W-1:0] SEL_LAST  = '0;
`else
    localparam logic [SEL_W-1:0] SEL_FIRST = '0;
    localparam logic [SEL_W-1:0] SEL_LAST  = '1;
`endif

    localparam logic [3:0] CNT_INIT = 4'((SETTLE > 0) ? SETTLE - 1 : 0);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [N-1:0]     r_word;
    logic [N-1:0]     w_word_nxt;
    logic [SEL_W-1:0] r_sel;
    logic [SEL_W-1:0] w_sel_nxt;
    logic [SEL_W-1:0] w_sel_step;
    logic [3:0]       r_cnt;
    logic [3:0]       w_cnt_nxt;
    logic             w_xfer;
    logic             w_last;

`ifdef MUX_SCAN_MSB_FIRST_EN
    assign w_sel_step = r_sel - 1'b1;
`else
    assign w_sel_step = r_sel + 1'b1;
`endif

    assign w_last = (r_sel == SEL_LAST);
    assign w_xfer = (r_state == S_PRESENT) && bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_word  <= '0;
            r_sel   <= SEL_FIRST;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_word  <= w_word_nxt;
            r_sel   <= w_sel_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_word_nxt  = r_word;
        w_sel_nxt   = r_sel;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            S_IDLE: begin
                if (bus.in_valid) begin
                    w_word_nxt = bus.in;
                    w_sel_nxt  = SEL_FIRST;
                    if (SETTLE > 0) begin
                        w_state_nxt = S_SETTLE;
                        w_cnt_nxt   = CNT_INIT;
                    end else begin
                        w_state_nxt = S_PRESENT;
                    end
                end
            end
            S_SETTLE: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_PRESENT;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            S_PRESENT: begin
                if (w_xfer) begin
                    if (w_last) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        // sel stops at the last index; it never wraps inside a word
                        w_sel_nxt = w_sel_step;
                        if (SETTLE > 0) begin
                            w_state_nxt = S_SETTLE;
                            w_cnt_nxt   = CNT_INIT;
                        end
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.out_valid = (r_state == S_PRESENT);
    assign bus.out_last  = (r_state == S_PRESENT) && w_last;
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.sel       = r_sel;
    assign bus.out       = r_word[r_sel];
endmodule

// File: doc/mux_scan_serializer.md
# mux_scan_serializer

- Sequencer that sits directly upstream of the 16:1 select mux.
- Accepts a parallel word through a valid/ready handshake, then walks the select line across every input position.
- Presents one selected bit per transfer on a valid/ready serial output, flagging the final bit.
- Drives the exposed `sel` bus that a downstream mux, or the embedded selection path, consumes.

## Interface

Parameters:
- `SEL_W`, default 4: select width; word width N = 2**SEL_W (16 by default).
- `SETTLE`, default 0: idle cycles `sel` is held stable before `out_valid` asserts for each bit (0..15).

Ports:
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `in_valid`  input  1  parallel word offered.
- `in_ready`  output  1  block can accept a word.
- `in`  input  N  parallel word.
- `sel`  output  SEL_W  current select index.
- `out`  output  1  selected bit, `word_q[sel]`.
- `out_valid`  output  1  `out` is valid.
- `out_ready`  input  1  consumer takes `out`.
- `out_last`  output  1  current bit is the final index of the word.
- `busy`  output  1  a word is being scanned (not IDLE).

## Operation

- States:
  - IDLE: `in_ready`=1.
  - SETTLE: wait counter running, `out_valid`=0.
  - PRESENT: `out_valid`=1.
- IDLE transitions:
  - On `in_valid && in_ready`: capture `in` into `word_q` and set `sel` to the first index.
  - Go to SETTLE if `SETTLE`>0, else PRESENT.
  - `in` is ignored in all other states.
- SETTLE: counter loads `SETTLE-1` on entry, decrements each cycle, and moves to PRESENT when it reads 0.
- PRESENT:
  - Hold `sel` and `out` until `out_valid && out_ready`.
  - On transfer with `out_last`=0: step `sel` to the next index, then go to SETTLE (`SETTLE`>0) or stay in PRESENT.
  - On transfer with `out_last`=1: go to IDLE.
- Scan order is LSB-first by default: `sel` runs 0,1,…,N-1; `out_last` = (`sel`==N-1). See Configuration for MSB-first.
- `sel` never wraps within a word; the index after the last is never driven.
- `out` is combinational from the registered `word_q` and `sel`; it is stable whenever `out_valid`=1.
- `out_ready` is ignored unless `out_valid`=1.
- `in_valid` held high while busy has no effect; a new word is accepted only in IDLE.

## Timing

- Reset values (asynchronous, immediate on `rst_n`=0):
  - `in_ready`=1, `out_valid`=0, `out_last`=0, `busy`=0.
  - `word_q`=0; `sel`=first index (0, or N-1 when MSB-first); `out`=0.
  - State IDLE.
- Reset asserted mid-scan aborts the word with no further `out_valid`; the first cycle after release is IDLE.
- Latency: acceptance at edge k; `out_valid` rises in cycle k+1+`SETTLE`.
- Per bit: with `out_ready` held at 1, each subsequent bit occupies 1+`SETTLE` cycles.
- Final transfer at edge m; `in_ready`=1 in cycle m+1. This gives one mandatory bubble between words.
- Best-case word period (`SETTLE`=0, `out_ready`=1): N+1 cycles.
- `sel` changes only on an accepted transfer or a word acceptance, never during SETTLE or while stalled.

## Configuration

- Macro `MUX_SCAN_MSB_FIRST_EN`.
- Defined:
  - `sel` starts at N-1 and decrements; `out_last` = (`sel`==0).
  - Reset value of `sel` is N-1.
- Undefined: LSB-first order as described above.
- Handshake and timing are identical in both builds.

## Test plan

- Reset, `SETTLE`=0, `out_ready`=1, offer `in`=16'hABCD:
  - `out` sequence for `sel` 0..15 is 1,0,1,1, 0,0,1,1, 1,1,0,1, 0,1,0,1.
  - `out_last` high only at `sel`=15.
  - `in_ready` returns one cycle after the last transfer.
- Same word with `MUX_SCAN_MSB_FIRST_EN` defined:
  - `sel` runs 15..0; `out` sequence 1,0,1,0, 1,0,1,1, 1,1,0,0, 1,1,0,1.
  - `out_last` high at `sel`=0.
- Backpressure, `SETTLE`=0: drop `out_ready` for 3 cycles at `sel`=5:
  - `sel`=5 and `out`=0 are held all 3 cycles.
  - No bit is lost or duplicated; the 16 transfers total.
- `SETTLE`=2:
  - `out_valid` first rises 3 cycles after acceptance.
  - Each bit spans 3 cycles with `out_valid` low for the first 2.
  - `sel` is stable throughout.
- `in_valid` held high with 16'hFFFF then 16'h0001:
  - Second word accepted only in the IDLE cycle after the first word's `out_last` transfer.
  - Outputs are 16 ones, then 1 followed by 15 zeros.
- Assert `rst_n`=0 at `sel`=7 mid-scan:
  - `out_valid`=0, `sel`=0, `busy`=0 immediately.
  - After release, a fresh 16'h8000 scans with `out`=1 only at `sel`=15.
